// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter: FSM states, response codes
// and width helpers.
package bus_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ALARM = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Latched response codes of the last transfer (rsp port).
  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_EN   = 2'd2;
  localparam logic [1:0] RSP_PE   = 2'd3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned bits_for(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational request picker for the bus arbiter.
// Ports:
//   req   - N request lines, bit i = module i
//   ptr   - rotating start index (ignored in fixed-priority mode)
//   valid - at least one request is set
//   idx   - index of the winning request
module prio_pick
  import bus_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned IDX_W       = bits_for(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] base;
  logic [2*N-1:0]   req2;
  logic [N-1:0]     rot;

  // Fixed priority is rotating priority with the start pinned to zero.
  assign base = (ROUND_ROBIN != 0) ? ptr : '0;
  assign req2 = {req, req};
  assign rot  = N'(req2 >> base);

  // Lowest set bit of the rotated vector, mapped back to a module index.
  always_comb begin
    logic [31:0] sum;
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = 32'(base) + 32'(k);
        if (sum >= 32'(N)) begin
          sum = sum - 32'(N);
        end
        idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// System bus arbiter: grants the shared bus to one requesting module at a
// time, watches slave responses to end a transfer, raises a timed alarm when
// no slave answers, and inserts a one-cycle release gap between owners.
// Ports:
//   __clk  - system clock
//   clo    - general clear, synchronous active-high
//   zg     - bus requests, bit i = module i (0 = CPU)
//   rok    - slave response OK
//   ren    - slave response EN (no unit)
//   rpe    - slave response PE (parity error)
//   zw     - bus grant, one-hot or zero
//   talarm - no-answer alarm pulse to the current owner
//   owner  - index of the current or most recent owner
//   busy   - high in every state except IDLE
//   rsp    - response of the last transfer (none/ok/en/pe-or-alarm)
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned ROUND_ROBIN     = 0,
  parameter int unsigned ALARM_DLY_TICKS = 200,
  parameter int unsigned ALARM_TICKS     = 8
) (
  input  logic         __clk,
  input  logic         clo,
  input  logic [N-1:0] zg,
  input  logic         rok,
  input  logic         ren,
  input  logic         rpe,
  output logic [N-1:0] zw,
  output logic         talarm,
  output logic [2:0]   owner,
  output logic         busy,
  output logic [1:0]   rsp
);

  localparam int unsigned IDX_W  = bits_for(N);
  localparam int unsigned CNT_W  = bits_for(ALARM_DLY_TICKS);
  localparam int unsigned ACNT_W = bits_for(ALARM_TICKS);

  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(ALARM_DLY_TICKS - 1);
  localparam logic [ACNT_W-1:0] ALM_LAST = ACNT_W'(ALARM_TICKS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACNT_W-1:0]  acnt_q, acnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [N-1:0]       zw_q, zw_d;
  logic [1:0]         rsp_q, rsp_d;
  logic               talarm_q, talarm_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               own_req;
  logic               any_rsp;
  logic [1:0]         rsp_code;
  logic               new_grant;

  prio_pick #(
    .N           (N),
    .ROUND_ROBIN (ROUND_ROBIN),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req   (zg),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign own_req   = zg[owner_q];
  assign any_rsp   = rok | ren | rpe;
  assign rsp_code  = rpe ? RSP_PE : (ren ? RSP_EN : RSP_OK);
  assign new_grant = (state_q == IDLE) && pick_valid;

  // State register.
  always_ff @(posedge __clk) begin
    if (clo) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response beats an abort, which beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = GRANT;
      end
      GRANT: begin
        if (any_rsp)                 state_d = DONE;
        else if (!own_req)           state_d = GAP;
        else if (cnt_q == TMO_LAST)  state_d = ALARM;
      end
      ALARM: begin
        if (acnt_q == ALM_LAST) state_d = DONE;
      end
      DONE: begin
        if (!own_req) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of registered outputs, counters and rotating pointer.
  always_comb begin
    logic [31:0] nxt;
    nxt      = '0;
    zw_d     = zw_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    rsp_d    = rsp_q;
    cnt_d    = cnt_q;
    acnt_d   = '0;
    talarm_d = (state_d == ALARM);
    busy_d   = (state_d != IDLE);

    if (new_grant) begin
      owner_d = pick_idx;
      nxt     = 32'(pick_idx) + 32'd1;
      ptr_d   = (nxt >= 32'(N)) ? '0 : IDX_W'(nxt);
    end

    if ((state_d == IDLE) || (state_d == GAP)) begin
      zw_d = '0;
    end else if (new_grant) begin
      zw_d = N'(1) << pick_idx;
    end

    // Timeout counter: cleared while idle, saturating count while granted.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if ((state_q == GRANT) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if ((state_q == ALARM) && (acnt_q != '1)) begin
      acnt_d = acnt_q + ACNT_W'(1);
    end

    if (state_q == GRANT) begin
      if (any_rsp)                rsp_d = rsp_code;
      else if (!own_req)          rsp_d = RSP_NONE;
      else if (state_d == ALARM)  rsp_d = RSP_PE;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge __clk) begin
    if (clo) begin
      zw_q     <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      rsp_q    <= RSP_NONE;
      cnt_q    <= '0;
      acnt_q   <= '0;
      talarm_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      zw_q     <= zw_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rsp_q    <= rsp_d;
      cnt_q    <= cnt_d;
      acnt_q   <= acnt_d;
      talarm_q <= talarm_d;
      busy_q   <= busy_d;
    end
  end

  assign zw     = zw_q;
  assign talarm = talarm_q;
  assign owner  = 3'(owner_q);
  assign busy   = busy_q;
  assign rsp    = rsp_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a fixed-priority and a rotating-priority instance
// share one stimulus stream and are compared every cycle against a
// transfer-level reference model, plus spot checks at key points.
module tb_bus_arbiter;

  localparam int NB  = 4;
  localparam int DLY = 12;
  localparam int ALT = 8;

  logic          clk;
  logic          clo;
  logic [NB-1:0] zg;
  logic          rok, ren, rpe;

  logic [NB-1:0] zw_f, zw_r;
  logic          talarm_f, talarm_r;
  logic [2:0]    owner_f, owner_r;
  logic          busy_f, busy_r;
  logic [1:0]    rsp_f, rsp_r;

  int n_chk;
  int n_err;

  // Reference model, index 0 = fixed priority, 1 = rotating priority.
  int m_hold [2];
  int m_gap  [2];
  int m_owner[2];
  int m_age  [2];
  int m_alarm[2];
  int m_ans  [2];
  int m_rsp  [2];
  int m_ptr  [2];

  bus_arbiter #(
    .N(NB), .ROUND_ROBIN(0), .ALARM_DLY_TICKS(DLY), .ALARM_TICKS(ALT)
  ) u_fix (
    .__clk(clk), .clo(clo), .zg(zg), .rok(rok), .ren(ren), .rpe(rpe),
    .zw(zw_f), .talarm(talarm_f), .owner(owner_f), .busy(busy_f), .rsp(rsp_f)
  );

  bus_arbiter #(
    .N(NB), .ROUND_ROBIN(1), .ALARM_DLY_TICKS(DLY), .ALARM_TICKS(ALT)
  ) u_rr (
    .__clk(clk), .clo(clo), .zg(zg), .rok(rok), .ren(ren), .rpe(rpe),
    .zw(zw_r), .talarm(talarm_r), .owner(owner_r), .busy(busy_r), .rsp(rsp_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner by the priority rules: scan upward from the start, wrapping.
  function automatic int pick(input int r, input logic [NB-1:0] z);
    int s;
    s = (r == 1) ? m_ptr[1] : 0;
    for (int k = 0; k < NB; k++) begin
      if (z[(s + k) % NB]) return (s + k) % NB;
    end
    return -1;
  endfunction

  task automatic model_step(input int r);
    int w;
    if (clo) begin
      m_hold[r] = 0; m_gap[r] = 0; m_owner[r] = 0; m_age[r] = 0;
      m_alarm[r] = 0; m_ans[r] = 0; m_rsp[r] = 0; m_ptr[r] = 0;
    end else if (m_gap[r] != 0) begin
      m_gap[r] = 0;
    end else if (m_hold[r] == 0) begin
      w = pick(r, zg);
      if (w >= 0) begin
        m_hold[r] = 1; m_owner[r] = w; m_age[r] = 0; m_ans[r] = 0;
        m_ptr[r] = (w + 1) % NB;
      end
    end else if (m_alarm[r] > 0) begin
      m_alarm[r]--;
      if (m_alarm[r] == 0) m_ans[r] = 1;
    end else if (m_ans[r] != 0) begin
      if (!zg[m_owner[r]]) begin
        m_hold[r] = 0; m_gap[r] = 1;
      end
    end else begin
      if (rok || ren || rpe) begin
        m_rsp[r] = rpe ? 3 : (ren ? 2 : 1);
        m_ans[r] = 1;
      end else if (!zg[m_owner[r]]) begin
        m_rsp[r] = 0; m_hold[r] = 0; m_gap[r] = 1;
      end else if (m_age[r] == DLY - 1) begin
        m_alarm[r] = ALT; m_rsp[r] = 3;
      end
      m_age[r]++;
    end
  endtask

  task automatic compare_all();
    chk("zw_fix",     32'(zw_f),     (m_hold[0] != 0) ? (32'd1 << m_owner[0]) : 32'd0);
    chk("talarm_fix", 32'(talarm_f), 32'(m_alarm[0] > 0));
    chk("owner_fix",  32'(owner_f),  32'(m_owner[0]));
    chk("busy_fix",   32'(busy_f),   32'((m_hold[0] != 0) || (m_gap[0] != 0)));
    chk("rsp_fix",    32'(rsp_f),    32'(m_rsp[0]));
    chk("zw_rr",      32'(zw_r),     (m_hold[1] != 0) ? (32'd1 << m_owner[1]) : 32'd0);
    chk("talarm_rr",  32'(talarm_r), 32'(m_alarm[1] > 0));
    chk("owner_rr",   32'(owner_r),  32'(m_owner[1]));
    chk("busy_rr",    32'(busy_r),   32'((m_hold[1] != 0) || (m_gap[1] != 0)));
    chk("rsp_rr",     32'(rsp_r),    32'(m_rsp[1]));
  endtask

  // One clock: drive inputs, let both DUT and model advance, compare.
  task automatic step(input logic [NB-1:0] z, input logic ok, input logic en,
                      input logic pe, input logic cl);
    zg = z; rok = ok; ren = en; rpe = pe; clo = cl;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet(input logic [NB-1:0] z, input int n);
    for (int i = 0; i < n; i++) step(z, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NB-1:0] z;
    n_chk = 0;
    n_err = 0;
    zg = '0; rok = 0; ren = 0; rpe = 0; clo = 1;
    @(negedge clk);

    // Reset state.
    step(4'b0000, 0, 0, 0, 1);
    chk("rst_zw", 32'(zw_f), 0);
    chk("rst_busy", 32'(busy_f), 0);
    chk("rst_rsp", 32'(rsp_r), 0);

    // Single transfer: grant after one cycle, OK response, release gap.
    step(4'b0001, 0, 0, 0, 0);
    chk("t1_zw", 32'(zw_f), 32'h1);
    chk("t1_busy", 32'(busy_f), 1);
    step(4'b0001, 1, 0, 0, 0);
    chk("t1_rsp", 32'(rsp_f), 1);
    step(4'b0000, 0, 0, 0, 0);
    chk("t1_gap_zw", 32'(zw_f), 0);
    chk("t1_gap_busy", 32'(busy_f), 1);
    step(4'b0000, 0, 0, 0, 0);
    chk("t1_idle_busy", 32'(busy_f), 0);

    // zg=1010: fixed grants 1,1,1; rotating grants 1,3,1.
    step(4'b1010, 0, 0, 0, 0);
    chk("t2_fix_a", 32'(owner_f), 1);
    chk("t2_rr_a", 32'(owner_r), 1);
    step(4'b1010, 1, 0, 0, 0);
    step(4'b1000, 0, 0, 0, 0);
    step(4'b1010, 0, 0, 0, 0);
    step(4'b1010, 0, 0, 0, 0);
    chk("t2_fix_b", 32'(owner_f), 1);
    chk("t2_rr_b", 32'(owner_r), 3);
    step(4'b1010, 1, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0);
    step(4'b1010, 0, 0, 0, 0);
    step(4'b1010, 0, 0, 0, 0);
    chk("t2_fix_c", 32'(owner_f), 1);
    chk("t2_rr_c", 32'(owner_r), 1);
    step(4'b1010, 1, 0, 0, 0);
    quiet(4'b0000, 2);

    // No answer: alarm after DLY cycles, ALT cycles wide, rok ignored.
    step(4'b0001, 0, 0, 0, 0);
    quiet(4'b0001, DLY - 1);
    chk("t3_pre_alarm", 32'(talarm_f), 0);
    quiet(4'b0001, 1);
    chk("t3_alarm", 32'(talarm_f), 1);
    chk("t3_rsp", 32'(rsp_f), 3);
    step(4'b0001, 1, 0, 0, 0);
    quiet(4'b0001, ALT - 2);
    chk("t3_alarm_end", 32'(talarm_f), 1);
    quiet(4'b0001, 1);
    chk("t3_alarm_off", 32'(talarm_f), 0);
    chk("t3_rsp_hold", 32'(rsp_f), 3);
    quiet(4'b0000, 2);

    // Response coinciding with the timeout wins.
    step(4'b0001, 0, 0, 0, 0);
    quiet(4'b0001, DLY - 1);
    step(4'b0001, 1, 0, 0, 0);
    chk("t4_edge_talarm", 32'(talarm_f), 0);
    chk("t4_edge_rsp", 32'(rsp_f), 1);
    quiet(4'b0000, 2);
    // Simultaneous OK and PE report PE.
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 1, 0, 1, 0);
    chk("t4_pe_rsp", 32'(rsp_f), 3);
    quiet(4'b0000, 2);

    // Owner abort with a waiting request: gap, then grant 2 cycles later.
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0);
    chk("t5_abort_zw", 32'(zw_f), 0);
    chk("t5_abort_rsp", 32'(rsp_f), 0);
    step(4'b0100, 0, 0, 0, 0);
    chk("t5_idle_zw", 32'(zw_f), 0);
    step(4'b0100, 0, 0, 0, 0);
    chk("t5_grant_zw", 32'(zw_f), 32'h4);

    // Clear in the middle of an alarm.
    quiet(4'b0100, DLY + 2);
    chk("t6_in_alarm", 32'(talarm_r), 1);
    step(4'b0100, 0, 0, 0, 1);
    chk("t6_zw", 32'(zw_r), 0);
    chk("t6_talarm", 32'(talarm_r), 0);
    chk("t6_busy", 32'(busy_r), 0);
    chk("t6_rsp", 32'(rsp_r), 0);
    step(4'b1010, 0, 0, 0, 0);
    chk("t6_ptr_reset", 32'(owner_r), 1);
    step(4'b1010, 1, 0, 0, 0);
    quiet(4'b0000, 2);

    // Randomized traffic.
    z = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 11) == 0) z[b] = ~z[b];
      end
      step(z, ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
